ras_spec_ctrl: RTL

//  Sequences one ras_stage for the fetch/commit pipeline.
//  - Accepts speculative call/return predictions from fetch and issues stage triggers with write/pop addresses.
//  - Keeps the speculative and committed top-of-stack pointers.
//  - Retires the oldest pending stage action on each in-order resolution from the backend.
//  - On a mispredict, flushes the stage and rolls the speculative pointer back to the committed one.

---
 rtl/ras_spec_ctrl_if.sv | 43 ++++
 rtl/ras_spec_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/ras_spec_ctrl_if.sv
// Fetch/backend <-> controller <-> ras_stage signal bundle.
// master drives predictions and resolutions; slave is the controller.
interface ras_spec_ctrl_if #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  pred_valid;
  logic                  pred_ready;
  logic                  pred_push;
  logic                  pred_pop;
  logic [WIDTH-1:0]      pred_data;
  logic                  res_valid;
  logic                  res_mispredict;
  logic                  head_push;
  logic                  stg_trigger;
  logic                  stg_push;
  logic                  stg_pop;
  logic [WIDTH-1:0]      stg_data;
  logic [ADDR_WIDTH-1:0] stg_addr;
  logic                  stg_commit;
  logic                  stg_flush;
  logic [ADDR_WIDTH-1:0] stg_rd_addr;
  logic [CW-1:0]         pending;

  modport master (
    output pred_valid, pred_push, pred_pop, pred_data,
    output res_valid, res_mispredict, head_push,
    input  pred_ready, stg_trigger, stg_push, stg_pop,
    input  stg_data, stg_addr, stg_commit, stg_flush,
    input  stg_rd_addr, pending
  );

  modport slave (
    input  pred_valid, pred_push, pred_pop, pred_data,
    input  res_valid, res_mispredict, head_push,
    output pred_ready, stg_trigger, stg_push, stg_pop,
    output stg_data, stg_addr, stg_commit, stg_flush,
    output stg_rd_addr, pending
  );
endinterface

// File: rtl/ras_spec_ctrl.sv
// Speculative/committed return-stack pointer controller for one ras_stage.
// Issues stage actions, retires them in order, and recovers on mispredict.
module ras_spec_ctrl #(
  parameter int DEPTH      = 16,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic            clk,
  input logic            reset,
  ras_spec_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RUN     = 2'd0;
  localparam logic [1:0] FLUSH   = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] spec_ptr;
  logic [ADDR_WIDTH-1:0] commit_ptr;
  logic [ADDR_WIDTH-1:0] spec_dec;
  logic [ADDR_WIDTH-1:0] commit_dec;
  logic [CW-1:0]         cnt;
  logic [1:0]            fifo [DEPTH];
  logic [IW-1:0]         rd_idx;
  logic [IW-1:0]         wr_idx;
  logic [IW-1:0]         rd_nxt;
  logic [IW-1:0]         wr_nxt;
  logic [1:0]            head;
  logic                  run;
  logic                  has_pend;
  logic                  mispred;
  logic                  commit;
  logic                  ready;
  logic                  accept;

  assign spec_dec   = spec_ptr - ADDR_WIDTH'(1);
  assign commit_dec = commit_ptr - ADDR_WIDTH'(1);
  assign rd_nxt     = (rd_idx == IW'(DEPTH - 1)) ? '0 : rd_idx + IW'(1);
  assign wr_nxt     = (wr_idx == IW'(DEPTH - 1)) ? '0 : wr_idx + IW'(1);
  assign head       = fifo[rd_idx];

  assign run      = (state == RUN) && !reset;
  assign has_pend = (cnt != '0);
  assign mispred  = run && bus.res_valid && bus.res_mispredict && has_pend;
  assign commit   = run && bus.res_valid && !bus.res_mispredict && has_pend;
  assign ready    = run && (cnt < CW'(DEPTH)) && !mispred;
  assign accept   = bus.pred_valid && ready
                 && (bus.pred_push || bus.pred_pop);

  assign bus.pred_ready  = ready;
  assign bus.stg_trigger = accept;
  assign bus.stg_push    = accept && bus.pred_push;
  assign bus.stg_pop     = accept && bus.pred_pop;
  assign bus.stg_data    = accept ? bus.pred_data : '0;
  assign bus.stg_addr    = !accept     ? '0 :
                           bus.pred_pop ? spec_dec : spec_ptr;
  assign bus.stg_commit  = commit;
  assign bus.stg_flush   = !reset && (state == FLUSH);
  assign bus.stg_rd_addr = reset          ? '0 :
                           (state == RUN) ? spec_dec : commit_dec;
  assign bus.pending     = reset ? '0 : cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      spec_ptr   <= '0;
      commit_ptr <= '0;
      cnt        <= '0;
      rd_idx     <= '0;
      wr_idx     <= '0;
    end else begin
      unique case (1'b1)
        state == RUN: begin
          if (mispred)
            state <= FLUSH;
          if (accept && !bus.pred_pop)
            spec_ptr <= spec_ptr + ADDR_WIDTH'(1);
          else if (accept && !bus.pred_push)
            spec_ptr <= spec_dec;
          // replace (push+pop) leaves the committed depth unchanged
          if (commit) begin
            rd_idx <= rd_nxt;
            if (head == 2'b10)
              commit_ptr <= commit_ptr + ADDR_WIDTH'(1);
            else if (head == 2'b01)
              commit_ptr <= commit_dec;
          end
          if (accept)
            wr_idx <= wr_nxt;
          cnt <= cnt + CW'(accept) - CW'(commit);
        end
        state == FLUSH: begin
          spec_ptr <= commit_ptr;
          cnt      <= '0;
          rd_idx   <= '0;
          wr_idx   <= '0;
          state    <= RECOVER;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept)
      fifo[wr_idx] <= {bus.pred_push, bus.pred_pop};
  end

  always @(posedge clk) begin
    if (run && bus.res_valid)
      assert (has_pend)
        else $error("res_valid with no pending action");
    if (commit)
      assert (bus.head_push == head[1])
        else $error("head_push disagrees with shadow FIFO head");
  end
endmodule
